i2c_slave_responder: RTL

- I2C target (slave) for 7-bit addressing. It is the bus-side counterpart of the master driver/engine pair, so the team can loop master traffic back in simulation and on FPGA.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches its address, and shifts bytes.
- Received bytes go out on a strobe; bytes to transmit come in through a request/data handshake.
- Open-drain style: the block only ever drives SDA low.

---
 rtl/i2c_pkg.sv | 7 +
 rtl/i2c_line_filter.sv | 30 +++
 rtl/i2c_slave_responder.sv | 102 ++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C FSM states and bus-level constants
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE} state_t;
  localparam logic READ = 1'b1;
  localparam logic SCL_IDLE = 1'b1;
  localparam logic SDA_IDLE = 1'b1;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF sync, N-sample glitch filter and edge pulses for one bus line
module i2c_line_filter #(
  parameter int FILTER_LEN = 2,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic [FILTER_LEN-1:0] hist;
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync  <= {2{IDLE_LVL}};
      hist  <= {FILTER_LEN{IDLE_LVL}};
      level <= IDLE_LVL;
      prev  <= IDLE_LVL;
    end else begin
      sync  <= {sync[0], pad};
      hist  <= FILTER_LEN'({hist, sync[1]});
      level <= &hist ? 1'b1 : ~|hist ? 1'b0 : level;
      prev  <= level;
    end
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: 7-bit-address I2C target with rx strobe and tx request handshake
module i2c_slave_responder import i2c_pkg::*; #(
  parameter logic [6:0] SLAVE_ADDR = 7'h77,
  parameter int FILTER_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  output logic       sdaOe,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  input  logic [7:0] txData,
  output logic       txReq,
  output logic       rw,
  output logic       busy,
  output logic       startDet,
  output logic       stopDet
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  state_t state, state_n;
  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] shift, shift_n, rx_data_n, sample;
  logic ack_ph, ph_n, rx_pend, rx_pend_n, rdy, rdy_n;
  logic oe_n, rx_valid_n, tx_req_n, rw_n, busy_n, start_n, stop_n;
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .IDLE_LVL(SCL_IDLE)) u_scl (
    .clk(clk), .reset(reset), .pad(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .IDLE_LVL(SDA_IDLE)) u_sda (
    .clk(clk), .reset(reset), .pad(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));
  assign sample = {shift[6:0], sda_lvl};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE; bit_cnt <= '0; shift <= '0; ack_ph <= 1'b0; rx_pend <= 1'b0; rdy <= 1'b0;
      sdaOe <= 1'b0; rxData <= '0; rxValid <= 1'b0; txReq <= 1'b0; rw <= 1'b0; busy <= 1'b0;
      startDet <= 1'b0; stopDet <= 1'b0;
    end else begin
      state <= state_n; bit_cnt <= cnt_n; shift <= shift_n; ack_ph <= ph_n; rx_pend <= rx_pend_n; rdy <= rdy_n;
      sdaOe <= oe_n; rxData <= rx_data_n; rxValid <= rx_valid_n; txReq <= tx_req_n; rw <= rw_n; busy <= busy_n;
      startDet <= start_n; stopDet <= stop_n;
    end
  always_comb begin
    state_n = state; cnt_n = bit_cnt; shift_n = shift; ph_n = ack_ph; rx_pend_n = 1'b0;
    rdy_n = rxValid ? rxReady : rdy;
    oe_n = sdaOe; rx_data_n = rxData; rx_valid_n = rx_pend; tx_req_n = 1'b0;
    rw_n = rw; busy_n = busy; start_n = 1'b0; stop_n = 1'b0;
    // bus conditions pre-empt any SCL edge seen in the same cycle
    if (sda_fall && scl_lvl) begin
      state_n = ADDR; cnt_n = '0; oe_n = 1'b0; start_n = 1'b1;
    end else if (sda_rise && scl_lvl) begin
      state_n = IDLE; oe_n = 1'b0; busy_n = 1'b0; stop_n = 1'b1;
    end else
      case (state)
        ADDR: if (scl_rise) begin
          shift_n = sample; cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (sample[7:1] == SLAVE_ADDR) begin
              rw_n = sample[0]; busy_n = 1'b1; ph_n = 1'b0; state_n = ADDR_ACK;
            end else state_n = IGNORE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          ph_n = 1'b1;
          if (!ack_ph) begin
            oe_n = 1'b1; tx_req_n = (rw == READ);
          end else if (rw == READ) begin
            shift_n = txData; oe_n = !txData[7]; state_n = TX;
          end else begin
            oe_n = 1'b0; state_n = RX;
          end
        end
        RX: if (scl_rise) begin
          shift_n = sample; cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_n = sample; rx_pend_n = 1'b1; ph_n = 1'b0; state_n = RX_ACK;
          end
        end
        RX_ACK: if (scl_fall) begin
          ph_n = 1'b1;
          if (!ack_ph) oe_n = rdy;
          else begin
            oe_n = 1'b0; cnt_n = '0; state_n = RX;
          end
        end
        TX: if (scl_fall) begin
          cnt_n = bit_cnt + 3'd1; shift_n = {shift[6:0], 1'b0};
          oe_n = (bit_cnt == 3'd7) ? 1'b0 : !shift[6];
          if (bit_cnt == 3'd7) state_n = TX_ACK;
        end
        TX_ACK:
          if (scl_rise) begin
            if (sda_lvl) begin
              oe_n = 1'b0; busy_n = 1'b0; state_n = IGNORE;
            end else tx_req_n = 1'b1;
          end else if (scl_fall) begin
            shift_n = txData; oe_n = !txData[7]; state_n = TX;
          end
        IGNORE: oe_n = 1'b0;
        default: ;
      endcase
  end
endmodule
